cordic_trig: RTL and testbench

CORDIC_TRIG -- requirements
Module: cordic_trig

---
 rtl/cordic_pkg.sv | 76 +++++++
 rtl/cordic_iter.sv | 38 +++
 rtl/cordic_trig.sv | 159 +++++++++++++++
 tb/tb_cordic_trig.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared constants, types and helpers for the CORDIC sine/cosine engine.
// External data format: Q9.16 two's complement (25 bits).
// Internal datapath: Q2.20 two's complement (22 bits).
package cordic_pkg;

  localparam int DATA_W   = 25;
  localparam int FRAC_W   = 16;
  localparam int DP_W     = 22;
  localparam int DP_FRAC  = 20;
  localparam int FRAC_GAP = DP_FRAC - FRAC_W;

  // CORDIC gain compensation, 0.607253 in Q2.20.
  localparam logic signed [DP_W-1:0] CORDIC_K = 22'sh09B74F;

  localparam logic signed [DATA_W-1:0] ONE_Q16 = 25'sh0010000;

  // Quadrant boundaries in Q9.16, rounded to nearest.
  localparam logic signed [DATA_W-1:0] PI_2  = 25'sh0019220;
  localparam logic signed [DATA_W-1:0] PI    = 25'sh003243F;
  localparam logic signed [DATA_W-1:0] PI3_2 = 25'sh004B65F;
  localparam logic signed [DATA_W-1:0] PI2   = 25'sh006487F;

  // The same angles at datapath precision, so that the residual handed to
  // the rotator does not inherit the Q16 rounding error times the quadrant.
  localparam logic [23:0] PI_2_Q20  = 24'h1921FB;
  localparam logic [23:0] PI_Q20    = 24'h3243F7;
  localparam logic [23:0] PI3_2_Q20 = 24'h4B65F2;
  localparam logic [23:0] PI2_Q20   = 24'h6487ED;

  typedef enum logic [1:0] {IDLE, MAP, ITER, FIX} state_t;

  // atan(2^-i) in Q.20, rounded to nearest.
  function automatic logic [DP_W-1:0] atan_lut(input logic [4:0] i);
    logic [DP_W-1:0] a;
    case (i)
      5'd0:  a = 22'h0C90FE;
      5'd1:  a = 22'h076B1A;
      5'd2:  a = 22'h03EB6F;
      5'd3:  a = 22'h01FD5C;
      5'd4:  a = 22'h00FFAB;
      5'd5:  a = 22'h007FF5;
      5'd6:  a = 22'h003FFF;
      5'd7:  a = 22'h002000;
      5'd8:  a = 22'h001000;
      5'd9:  a = 22'h000800;
      5'd10: a = 22'h000400;
      5'd11: a = 22'h000200;
      5'd12: a = 22'h000100;
      5'd13: a = 22'h000080;
      5'd14: a = 22'h000040;
      5'd15: a = 22'h000020;
      5'd16: a = 22'h000010;
      5'd17: a = 22'h000008;
      5'd18: a = 22'h000004;
      5'd19: a = 22'h000002;
      default: a = '0;
    endcase
    return a;
  endfunction

  // Q2.20 -> Q9.16, truncating toward zero. A result that truncates to zero
  // is replaced by one LSB carrying the sign of the internal value, so that
  // the sign of tiny results survives.
  function automatic logic [DATA_W-1:0] to_q16(input logic signed [DP_W-1:0] v);
    logic signed [DATA_W-1:0] ve;
    logic signed [DATA_W-1:0] mag;
    logic signed [DATA_W-1:0] t;
    ve  = {{(DATA_W-DP_W){v[DP_W-1]}}, v};
    mag = v[DP_W-1] ? -ve : ve;
    t   = mag >>> FRAC_GAP;
    if (t == '0)
      return v[DP_W-1] ? '1 : DATA_W'(1);
    return v[DP_W-1] ? -t : t;
  endfunction

endpackage

// File: rtl/cordic_iter.sv
// One CORDIC rotation-mode micro-rotation, purely combinational.
// Ports:
//   x, y, z                   current vector and residual angle (Q2.20)
//   i                         iteration index: shift amount and LUT entry
//   x_next, y_next, z_next    updated vector and residual angle
module cordic_iter
  import cordic_pkg::*;
(
  input  logic signed [DP_W-1:0] x,
  input  logic signed [DP_W-1:0] y,
  input  logic signed [DP_W-1:0] z,
  input  logic        [4:0]      i,
  output logic signed [DP_W-1:0] x_next,
  output logic signed [DP_W-1:0] y_next,
  output logic signed [DP_W-1:0] z_next
);

  logic signed [DP_W-1:0] x_sh;
  logic signed [DP_W-1:0] y_sh;
  logic signed [DP_W-1:0] ang;

  always_comb begin
    x_sh = x >>> i;
    y_sh = y >>> i;
    ang  = signed'(atan_lut(i));
    // Rotate toward z = 0: negative residual rotates clockwise.
    if (z[DP_W-1]) begin
      x_next = x + y_sh;
      y_next = y - x_sh;
      z_next = z + ang;
    end else begin
      x_next = x - y_sh;
      y_next = y + x_sh;
      z_next = z - ang;
    end
  end

endmodule

// File: rtl/cordic_trig.sv
// Iterative CORDIC sine/cosine. One request at a time; the result pair is
// strobed N_ITER+2 edges after the request is captured.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   theta, theta_valid  angle (Q9.16 radians, 0..2*pi) and request strobe
//   cos_data/cos_valid  cosine result (Q9.16) and one-cycle strobe
//   sin_data/sin_valid  sine result (Q9.16) and one-cycle strobe
//   busy                high while a request is in flight
//
// state | meaning
// IDLE  | waiting for theta_valid; result strobe cycle lands here
// MAP   | reduce captured angle to quadrant + residual, load rotator
// ITER  | N_ITER micro-rotations, one per cycle
// FIX   | undo quadrant reduction, convert and register results
module cordic_trig
  import cordic_pkg::*;
#(
  parameter int INT_WIDTH  = 9,
  parameter int FRAC_WIDTH = 16,
  parameter int N_ITER     = 20
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [INT_WIDTH+FRAC_WIDTH-1:0] theta,
  input  logic                            theta_valid,
  output logic [INT_WIDTH+FRAC_WIDTH-1:0] cos_data,
  output logic                            cos_valid,
  output logic [INT_WIDTH+FRAC_WIDTH-1:0] sin_data,
  output logic                            sin_valid,
  output logic                            busy
);

  state_t state, state_nx;

  logic        [4:0]        cnt;
  logic        [4:0]        iter_idx;
  logic signed [DATA_W-1:0] theta_r;
  logic        [1:0]        quad;
  logic signed [DP_W-1:0]   x, y, z;
  logic signed [DP_W-1:0]   x_n, y_n, z_n;

  logic                     wrap;
  logic signed [DATA_W-1:0] t16;
  logic        [1:0]        q_map;
  logic        [DP_W-1:0]   theta_lo;
  logic        [DP_W-1:0]   q_off;
  logic        [DP_W-1:0]   z_map;
  logic signed [DP_W-1:0]   cos_fix, sin_fix;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (theta_valid) state_nx = MAP;
      MAP:     state_nx = ITER;
      ITER:    if (cnt == 5'd0) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Quadrant decisions use the Q16 boundaries; the residual is formed at
  // Q20 precision. Only the low DP_W bits of the residual are kept, which
  // is exact for any in-range angle.
  always_comb begin
    wrap     = (theta_r >= PI2);
    t16      = wrap ? theta_r - PI2 : theta_r;
    if (t16 >= PI3_2)     q_map = 2'd3;
    else if (t16 >= PI)   q_map = 2'd2;
    else if (t16 >= PI_2) q_map = 2'd1;
    else                  q_map = 2'd0;
    theta_lo = {theta_r[DP_W-FRAC_GAP-1:0], FRAC_GAP'(0)};
    case (q_map)
      2'd1:    q_off = DP_W'(PI_2_Q20);
      2'd2:    q_off = DP_W'(PI_Q20);
      2'd3:    q_off = DP_W'(PI3_2_Q20);
      default: q_off = '0;
    endcase
    z_map = theta_lo - (wrap ? DP_W'(PI2_Q20) : '0) - q_off;
  end

  always_comb begin
    case (quad)
      2'd1:    begin cos_fix = -y; sin_fix =  x; end
      2'd2:    begin cos_fix = -x; sin_fix = -y; end
      2'd3:    begin cos_fix =  y; sin_fix = -x; end
      default: begin cos_fix =  x; sin_fix =  y; end
    endcase
  end

  // Counter runs down to terminal count 0; the rotator index counts up.
  assign iter_idx = 5'(N_ITER - 1) - cnt;

  cordic_iter u_iter (
    .x      (x),
    .y      (y),
    .z      (z),
    .i      (iter_idx),
    .x_next (x_n),
    .y_next (y_n),
    .z_next (z_n)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      theta_r   <= '0;
      quad      <= '0;
      cnt       <= '0;
      x         <= '0;
      y         <= '0;
      z         <= '0;
      cos_data  <= '0;
      sin_data  <= '0;
      cos_valid <= 1'b0;
      sin_valid <= 1'b0;
    end else begin
      cos_valid <= 1'b0;
      sin_valid <= 1'b0;
      cos_data  <= '0;
      sin_data  <= '0;
      case (state)
        IDLE: if (theta_valid) theta_r <= theta;
        MAP: begin
          quad <= q_map;
          x    <= CORDIC_K;
          y    <= '0;
          z    <= signed'(z_map);
          cnt  <= 5'(N_ITER - 1);
        end
        ITER: begin
          x <= x_n;
          y <= y_n;
          z <= z_n;
          if (cnt != 5'd0) cnt <= cnt - 5'd1;
        end
        FIX: begin
          cos_valid <= 1'b1;
          sin_valid <= 1'b1;
          // theta == 0 returns the exact pair instead of CORDIC residue.
          if (theta_r == '0) begin
            cos_data <= ONE_Q16;
            sin_data <= '0;
          end else begin
            cos_data <= to_q16(cos_fix);
            sin_data <= to_q16(sin_fix);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_trig.sv
module tb_cordic_trig;

  localparam real PI_R = 3.14159265358979323846;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [24:0] theta = '0;
  logic        theta_valid = 1'b0;
  logic [24:0] cos_data, sin_data;
  logic        cos_valid, sin_valid, busy;

  cordic_trig #(.INT_WIDTH(9), .FRAC_WIDTH(16), .N_ITER(20)) dut (
    .clk         (clk),
    .rst         (rst),
    .theta       (theta),
    .theta_valid (theta_valid),
    .cos_data    (cos_data),
    .cos_valid   (cos_valid),
    .sin_data    (sin_data),
    .sin_valid   (sin_valid),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string       name;
    logic [24:0] theta;
    logic [24:0] exp_cos;
    logic [24:0] exp_sin;
    int          tol;
    bit          sin_nz;
  } vec_t;

  vec_t vecs[7];

  task automatic check_eq(input string name, input logic [24:0] act, input logic [24:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%07h expected 0x%07h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_near(input string name, input logic [24:0] act, input logic [24:0] exp, input int tol);
    int d;
    n_cmp++;
    d = int'($signed(act)) - int'($signed(exp));
    if (d < 0) d = -d;
    if (d > tol) begin
      n_err++;
      $display("FAIL %s: got 0x%07h expected 0x%07h +/-%0d", name, act, exp, tol);
    end
  endtask

  // Called at the negedge right after the capture edge. Returns at the
  // negedge where the strobe is visible; edges counts posedges since capture.
  task automatic wait_result(output logic [24:0] c, output logic [24:0] s, output int edges,
                             output bit busy_ok, output bit both_ok, output bit zero_ok);
    edges = 0; busy_ok = 1; both_ok = 1; zero_ok = 1; c = '0; s = '0;
    while (edges < 40) begin
      if (cos_valid || sin_valid) begin
        c = cos_data;
        s = sin_data;
        both_ok = cos_valid && sin_valid;
        break;
      end
      if (!busy) busy_ok = 0;
      if (cos_data != '0 || sin_data != '0) zero_ok = 0;
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic pulse(input logic [24:0] t);
    theta = t;
    theta_valid = 1'b1;
    @(negedge clk);
    theta_valid = 1'b0;
  endtask

  task automatic check_idle_after(input string name);
    @(negedge clk);
    check_eq({name, " valids/busy after"}, {22'd0, cos_valid, sin_valid, busy}, 25'd0);
    check_eq({name, " cos zero after"}, cos_data, 25'd0);
    check_eq({name, " sin zero after"}, sin_data, 25'd0);
  endtask

  task automatic check_result(input string name, input logic [24:0] c, input logic [24:0] s,
                              input int edges, input bit busy_ok, input bit both_ok, input bit zero_ok,
                              input logic [24:0] ec, input logic [24:0] es, input int tol, input bit sin_nz);
    check_int({name, " latency"}, edges, 22);
    check_int({name, " busy held"}, int'(busy_ok), 1);
    check_int({name, " valids together"}, int'(both_ok), 1);
    check_int({name, " data zero while invalid"}, int'(zero_ok), 1);
    check_near({name, " cos"}, c, ec, tol);
    if (sin_nz)
      check_int({name, " sin nonzero lsb"}, int'(s == 25'h0000001 || s == 25'h1FFFFFF), 1);
    else
      check_near({name, " sin"}, s, es, tol);
  endtask

  initial begin
    logic [24:0] c, s;
    int edges, strobes, first_edge;
    bit busy_ok, both_ok, zero_ok;

    vecs[0] = '{"zero",   25'h0000000, 25'h0010000, 25'h0000000, 0, 1'b0};
    vecs[1] = '{"pi/6",   25'h000860B, 25'h000DDB3, 25'h0008000, 2, 1'b0};
    vecs[2] = '{"pi",     25'h003243F, 25'h1FF0000, 25'h0000000, 2, 1'b1};
    vecs[3] = '{"pi/4",   25'h000C910, 25'h000B504, 25'h000B505, 2, 1'b0};
    vecs[4] = '{"pi/2",   25'h0019220, 25'h0000000, 25'h000FFFF, 2, 1'b0};
    vecs[5] = '{"3pi/2",  25'h004B65F, 25'h0000000, 25'h1FF0001, 2, 1'b0};
    vecs[6] = '{"2pi wrap", 25'h006487F, 25'h0010000, 25'h0000000, 2, 1'b0};

    // Reset, with a request held during reset that must be ignored.
    theta = 25'h000860B;
    theta_valid = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("reset cos_data", cos_data, 25'd0);
    check_eq("reset sin_data", sin_data, 25'd0);
    check_eq("reset valids/busy", {22'd0, cos_valid, sin_valid, busy}, 25'd0);
    rst = 1'b0;
    theta_valid = 1'b0;
    @(negedge clk);
    check_eq("request during reset ignored", {24'd0, busy}, 25'd0);

    foreach (vecs[k]) begin
      pulse(vecs[k].theta);
      wait_result(c, s, edges, busy_ok, both_ok, zero_ok);
      check_result(vecs[k].name, c, s, edges, busy_ok, both_ok, zero_ok,
                   vecs[k].exp_cos, vecs[k].exp_sin, vecs[k].tol, vecs[k].sin_nz);
      check_idle_after(vecs[k].name);
    end

    // Second request 5 cycles into the first: must be dropped.
    theta = 25'h000860B;
    theta_valid = 1'b1;
    @(negedge clk);
    theta_valid = 1'b0;
    strobes = 0; first_edge = -1; busy_ok = 1; c = '0; s = '0;
    for (int k = 0; k < 60; k++) begin
      if (cos_valid || sin_valid) begin
        strobes++;
        if (first_edge < 0) begin
          first_edge = k;
          c = cos_data;
          s = sin_data;
        end
      end else if (first_edge < 0 && !busy) begin
        busy_ok = 0;
      end
      if (k == 5) begin
        theta = 25'h003243F;
        theta_valid = 1'b1;
      end else begin
        theta_valid = 1'b0;
      end
      @(negedge clk);
    end
    check_int("overlap strobe count", strobes, 1);
    check_int("overlap latency", first_edge, 22);
    check_int("overlap busy held", int'(busy_ok), 1);
    check_near("overlap cos", c, 25'h000DDB3, 2);
    check_near("overlap sin", s, 25'h0008000, 2);

    // Reset during ITER aborts; a request right after reset completes.
    pulse(25'h000860B);
    repeat (6) @(negedge clk);
    check_eq("busy before abort", {24'd0, busy}, 25'd1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort valids/busy", {22'd0, cos_valid, sin_valid, busy}, 25'd0);
    check_eq("abort cos_data", cos_data, 25'd0);
    check_eq("abort sin_data", sin_data, 25'd0);
    rst = 1'b0;
    pulse(25'h000C910);
    wait_result(c, s, edges, busy_ok, both_ok, zero_ok);
    check_result("post-abort", c, s, edges, busy_ok, both_ok, zero_ok,
                 25'h000B504, 25'h000B505, 2, 1'b0);
    check_idle_after("post-abort");

    // Back-to-back 1-degree sweep against a real-valued model.
    begin
      int tq, ec, es;
      real a;
      tq = 0;
      pulse(25'd0);
      for (int deg = 0; deg < 360; deg++) begin
        a  = real'(tq) / 65536.0;
        ec = $rtoi($cos(a) * 65536.0);
        es = $rtoi($sin(a) * 65536.0);
        wait_result(c, s, edges, busy_ok, both_ok, zero_ok);
        check_int($sformatf("sweep %0d latency", deg), edges, 22);
        check_near($sformatf("sweep %0d cos", deg), c, 25'(ec), 2);
        check_near($sformatf("sweep %0d sin", deg), s, 25'(es), 2);
        if (deg < 359) begin
          check_int($sformatf("sweep %0d idle at strobe", deg), int'(busy), 0);
          tq = $rtoi(real'(deg + 1) * PI_R / 180.0 * 65536.0 + 0.5);
          pulse(25'(tq));
        end
      end
      check_idle_after("sweep end");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
